ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_sync.sv | 44 ++++
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver:
// host FSM encodings, frame layout constants and the common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_XMIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_WAIT    = 3'd4,
    ST_DONE    = 3'd5
  } ps2_state_e;

  // Frame layout counted in device clock falling edges
  localparam int DATA_BITS   = 8;
  localparam int PARITY_FALL = 9;
  localparam int STOP_FALL   = 10;
  localparam int ACK_FALL    = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus registered
// falling-edge pulses. Idle bus is high, so flops reset to 1.
module ps2_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fall,
  output logic o_data_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_q;
  logic       r_data_q;
  logic       r_clk_fall;
  logic       r_data_fall;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_q     <= 1'b1;
      r_data_q    <= 1'b1;
      r_clk_fall  <= 1'b0;
      r_data_fall <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_q     <= r_clk_sync[1];
      r_data_q    <= r_data_sync[1];
      r_clk_fall  <= r_clk_q & ~r_clk_sync[1];
      r_data_fall <= r_data_q & ~r_data_sync[1];
    end
  end

  assign o_clk_s     = r_clk_sync[1];
  assign o_data_s    = r_data_sync[1];
  assign o_clk_fall  = r_clk_fall;
  assign o_data_fall = r_data_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte plus odd parity on device clock falls, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_done,
  output logic       o_error,
  output logic       o_busy,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e      r_state, w_state_d;
  logic [IW-1:0]   r_inh, w_inh_d;
  logic [WW-1:0]   r_wd, w_wd_d;
  logic [3:0]      r_bit_n, w_bit_n_d;
  logic [7:0]      r_byte, w_byte_d;
  logic            r_par, w_par_d;
  logic            r_data_oe, w_data_oe_d;
  logic            r_err, w_err_d;

  logic            w_clk_s;
  logic            w_data_s;
  logic            w_fall;
  logic            w_data_fall_unused;
  logic            w_wd_run;
  logic            w_timeout;

  ps2_sync u_sync (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_ps2_clk   (i_ps2_clk_in),
    .i_ps2_data  (i_ps2_data_in),
    .o_clk_s     (w_clk_s),
    .o_data_s    (w_data_s),
    .o_clk_fall  (w_fall),
    .o_data_fall (w_data_fall_unused)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_inh     <= '0;
      r_wd      <= '0;
      r_bit_n   <= '0;
      r_byte    <= '0;
      r_par     <= 1'b0;
      r_data_oe <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_inh     <= w_inh_d;
      r_wd      <= w_wd_d;
      r_bit_n   <= w_bit_n_d;
      r_byte    <= w_byte_d;
      r_par     <= w_par_d;
      r_data_oe <= w_data_oe_d;
      r_err     <= w_err_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_inh_d     = r_inh;
    w_wd_d      = r_wd;
    w_bit_n_d   = r_bit_n;
    w_byte_d    = r_byte;
    w_par_d     = r_par;
    w_data_oe_d = r_data_oe;
    w_err_d     = r_err;

    w_wd_run  = (r_state == ST_XMIT) || (r_state == ST_ACK) || (r_state == ST_WAIT);
    w_timeout = w_wd_run && (r_wd == WW'(TIMEOUT_CYCLES - 1));
    if (w_wd_run) w_wd_d = w_fall ? '0 : r_wd + 1'b1;

    // Timeout wins over a fall arriving in the same cycle
    if (w_timeout) begin
      w_state_d   = ST_DONE;
      w_data_oe_d = 1'b0;
      w_err_d     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_tx_valid) begin
            w_state_d   = ST_INHIBIT;
            w_inh_d     = '0;
            w_wd_d      = '0;
            w_bit_n_d   = '0;
            w_err_d     = 1'b0;
            w_byte_d    = i_tx_data;
            w_par_d     = odd_parity(i_tx_data);
            w_data_oe_d = (INHIBIT_CYCLES == 1);
          end
        end
        ST_INHIBIT: begin
          if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
            w_state_d = ST_XMIT;
            w_inh_d   = '0;
            w_wd_d    = '0;
          end else begin
            w_inh_d = r_inh + 1'b1;
            // Start bit goes out on the last inhibit cycle
            if (r_inh == IW'(INHIBIT_CYCLES - 2)) w_data_oe_d = 1'b1;
          end
        end
        ST_XMIT: begin
          if (w_fall) begin
            w_bit_n_d = r_bit_n + 1'b1;
            if (r_bit_n < 4'(DATA_BITS))
              w_data_oe_d = ~r_byte[r_bit_n[2:0]];
            else if (r_bit_n == 4'(PARITY_FALL - 1))
              w_data_oe_d = ~r_par;
            else begin
              w_data_oe_d = 1'b0;
              if (r_bit_n == 4'(STOP_FALL - 1)) w_state_d = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (w_fall) begin
            w_bit_n_d = r_bit_n + 1'b1;
            if (r_bit_n == 4'(ACK_FALL - 1)) begin
              w_err_d   = w_data_s;
              w_state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_clk_s && w_data_s) w_state_d = ST_DONE;
        end
        ST_DONE: w_state_d = ST_IDLE;
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  assign o_tx_ready    = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_error       = (r_state == ST_DONE) && r_err;
  assign o_ps2_clk_oe  = (r_state == ST_INHIBIT);
  assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on open-drain pins, per-cycle window model
// for handshake/inhibit outputs, and directed transactions with literal checks.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int IC   = 20;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, done, error, busy, clk_oe, data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       pin_clk, pin_data;

  assign pin_clk  = ~clk_oe & dev_clk;
  assign pin_data = ~data_oe & dev_data;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, m_acc = 0, done_cnt = 0, oe_run = 0, oe_last_run = 0;
  logic m_active = 1'b0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_ready(tx_ready), .o_done(done), .o_error(error), .o_busy(busy),
    .i_ps2_clk_in(pin_clk), .i_ps2_data_in(pin_data),
    .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Odd parity: parity bit makes the total count of ones odd
  function automatic logic par_model(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  // Transaction window model: a transaction starts on any edge where valid is
  // seen while idle and ends on the edge after done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) m_active <= 1'b0;
    else if (!m_active && tx_valid) begin
      m_active <= 1'b1;
      m_acc    <= cyc;
    end else if (m_active && done) m_active <= 1'b0;
  end

  always @(negedge clk) begin
    int k;
    if (done) done_cnt++;
    if (clk_oe) oe_run++;
    else if (oe_run != 0) begin oe_last_run = oe_run; oe_run = 0; end
    if (chk_en) begin
      k = cyc - m_acc;
      check("tx_ready", tx_ready, !m_active);
      check("busy", busy, m_active);
      if (!done) check("error_unqualified", error, 0);
      if (!m_active) begin
        check("spurious_done", done, 0);
        check("idle_clk_oe", clk_oe, 0);
        check("idle_data_oe", data_oe, 0);
      end else begin
        check("inhibit_clk_oe", clk_oe, (k >= 1 && k <= IC));
        if (k >= 1 && k < IC) check("inhibit_data_oe", data_oe, 0);
        else if (k == IC || k == IC + 1) check("start_bit_oe", data_oe, 1);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device BFM: waits for request-to-send, then gives npulse clock pulses,
  // reading data at each rising edge; pulse 11 carries the ACK.
  task automatic dev_xfer(input int npulse, input bit ack,
                          output logic [7:0] b, output logic p, output logic s);
    int t;
    b = '0; p = 1'b0; s = 1'b0;
    t = 0;
    while (!clk_oe && t < 100) begin @(negedge clk); t++; end
    check("rts_inhibit_seen", clk_oe, 1);
    t = 0;
    while (clk_oe && t < 100) begin @(negedge clk); t++; end
    check("rts_clk_released", clk_oe, 0);
    check("rts_start_pin", pin_data, 0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < npulse && i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 8) b[i] = pin_data;
      else if (i == 8) p = pin_data;
      else s = pin_data;
      repeat (HALF) @(negedge clk);
    end
    if (npulse >= 11) begin
      dev_data = ack ? 1'b0 : 1'b1;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int limit, output logic err, output int rel);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < limit);
    check("done_seen", done, 1);
    err = error;
    rel = cyc - m_acc;
  endtask

  task automatic full(input logic [7:0] b, input bit ack, input bit exp_err,
                      output logic [7:0] cap, output logic p);
    logic s, err;
    int rel;
    send(b);
    dev_xfer(11, ack, cap, p, s);
    for (int i = 0; i < 8; i++) check($sformatf("lsb_first_bit%0d", i), cap[i], b[i]);
    check("parity", p, par_model(b));
    check("stop_bit", s, 1);
    wait_done(200, err, rel);
    check("error_flag", err, exp_err);
    @(negedge clk);
    check("ready_after_done", tx_ready, 1);
    check("released_clk", clk_oe, 0);
    check("released_data", data_oe, 0);
  endtask

  initial begin
    logic [7:0] cap;
    logic p, s, err;
    int rel, d0;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (3) @(negedge clk);

    full(8'hED, 1'b1, 1'b0, cap, p);
    check("ed_byte", cap, 8'hED);
    check("ed_parity", p, 1);
    check("ed_inhibit_len", oe_last_run, 20);

    full(8'hF4, 1'b1, 1'b0, cap, p);
    check("f4_parity", p, 0);
    full(8'h00, 1'b1, 1'b0, cap, p);
    check("00_parity", p, 1);

    full(8'h55, 1'b0, 1'b1, cap, p);
    check("nack_byte", cap, 8'h55);

    // Device never clocks: timeout 400 cycles after the clock release
    send(8'hF4);
    dev_xfer(0, 1'b1, cap, p, s);
    wait_done(600, err, rel);
    check("timeout_error", err, 1);
    check("timeout_latency", rel, IC + 1 + TO);
    check("timeout_clk_oe", clk_oe, 0);
    check("timeout_data_oe", data_oe, 0);
    @(negedge clk);

    // Reset while data bit 4 (0 for 0xA5, so pulled low) is on the line
    send(8'hA5);
    dev_xfer(5, 1'b1, cap, p, s);
    check("a5_low_nibble", cap[3:0], 4'h5);
    check("bit4_driven", data_oe, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_clk_oe", clk_oe, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_ready", tx_ready, 1);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    check("midrst_no_done", done_cnt, d0);
    full(8'hFF, 1'b1, 1'b0, cap, p);
    check("ff_byte", cap, 8'hFF);

    // tx_valid held with a new byte during a transaction
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hED;
    @(negedge clk);
    tx_data  = 8'h42;
    dev_xfer(11, 1'b1, cap, p, s);
    check("held_first_byte", cap, 8'hED);
    wait_done(200, err, rel);
    check("held_first_err", err, 0);
    @(negedge clk);
    check("held_ready_gap", tx_ready, 1);
    @(negedge clk);
    check("held_reaccept_busy", busy, 1);
    check("held_reaccept_inhibit", clk_oe, 1);
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, cap, p, s);
    check("held_second_byte", cap, 8'h42);
    check("held_second_parity", p, 1);
    wait_done(200, err, rel);
    check("held_second_err", err, 0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
